apb4_clint_mh: RTL and testbench

- Multi-hart, parametrised successor of the single-hart APB4 CLINT.
- One shared 64-bit mtime, advanced by a synchronised, prescaled RTC tick.
- Per-hart msip and 64-bit mtimecmp.
- Adds over the single-hart block: writable mtime, independent 32-bit half writes, tear-free 64-bit mtime reads, registered interrupts, and pslverr on unmapped addresses.
- Sits on the APB4 peripheral bus; drives the machine software and timer interrupt lines of every hart.

---
 rtl/clint_pkg.sv | 31 +++
 rtl/clint_rtc_tick.sv | 42 ++++
 rtl/apb4_clint_mh.sv | 131 +++++++++++++
 tb/tb_apb4_clint_mh.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: shared constants for the multi-hart APB4 CLINT.
//   - register byte offsets (word aligned)
//   - register widths
//   - mtimecmp reset value
//   - apply_strb(): byte-lane merge of APB write data into a 32-bit half
package clint_pkg;

    localparam int CLINT_MSIP_BASE     = 'h000;
    localparam int CLINT_MTIMECMP_BASE = 'h400;
    localparam int CLINT_MTIMEL        = 'h7F8;
    localparam int CLINT_MTIMEH        = 'h7FC;

    localparam int CLINT_MSIP_W        = 1;
    localparam int CLINT_MTIME_W       = 64;
    localparam int CLINT_MTIMECMP_W    = 64;

    localparam logic [CLINT_MTIMECMP_W-1:0] CLINT_MTIMECMP_RST = '1;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_rtc_tick.sv
// clint_rtc_tick: turns the asynchronous RTC reference into a one-cycle
// mtime advance pulse in the clk_i domain.
//   clk_i      core clock
//   rst_i      synchronous active-high reset
//   rtc_clk_i  asynchronous RTC input
//   tick_o     one-cycle pulse every PRESCALE RTC rising edges
module clint_rtc_tick #(
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rtc_clk_i,
    output logic tick_o
);

    // PRESCALE=1 still needs a 1-bit counter; it simply never leaves 0.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;
    logic                   last;
    logic [CW-1:0]          cnt;

    assign rise   = sync[SYNC_STAGES-1] & ~prev;
    assign last   = (cnt == CW'(PRESCALE - 1));
    assign tick_o = rise & last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync <= '0;
            prev <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rtc_clk_i};
            prev <= sync[SYNC_STAGES-1];
            if (rise) cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/apb4_clint_mh.sv
// apb4_clint_mh: multi-hart core-local interruptor on APB4.
//   clk_i/rst_i        core clock, synchronous active-high reset
//   rtc_clk_i          asynchronous time base (prescaled into mtime ticks)
//   psel_i..pstrb_i    APB4 request; pready_o tied high (zero wait states)
//   prdata_o           read data, non-zero only during a read access
//   pslverr_o          asserted in the access cycle for unmapped addresses
//   sfr_irq_o          per-hart software interrupt (registered msip)
//   tmr_irq_o          per-hart timer interrupt (registered mtime >= mtimecmp)
module apb4_clint_mh
    import clint_pkg::*;
#(
    parameter int NUM_HART    = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rtc_clk_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic [31:0]           prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [NUM_HART-1:0]   sfr_irq_o,
    output logic [NUM_HART-1:0]   tmr_irq_o
);

    logic                                     access, wr, rd, tick;
    logic [ADDR_WIDTH-1:0]                    addr;
    logic                                     unused_addr;
    logic [NUM_HART-1:0]                      msip_hit, cmpl_hit, cmph_hit;
    logic                                     mtl_hit, mth_hit, mapped;
    logic [NUM_HART-1:0]                      msip;
    logic [NUM_HART-1:0][CLINT_MTIMECMP_W-1:0] mtimecmp;
    logic [CLINT_MTIME_W-1:0]                 mtime;
    logic [31:0]                              snap;
    logic [31:0]                              rdata;

    clint_rtc_tick #(
        .PRESCALE    (PRESCALE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rtc_clk_i (rtc_clk_i),
        .tick_o    (tick)
    );

    // Accesses during reset are ignored, including their error/read response.
    assign access      = psel_i & penable_i & ~rst_i;
    assign wr          = access & pwrite_i;
    assign rd          = access & ~pwrite_i;
    assign pready_o    = 1'b1;
    assign addr        = {paddr_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_addr = ^paddr_i[1:0];

    // Per-hart decode; harts beyond NUM_HART never match, so they fall to pslverr.
    always_comb begin
        msip_hit = '0;
        cmpl_hit = '0;
        cmph_hit = '0;
        for (int h = 0; h < NUM_HART; h++) begin
            msip_hit[h] = (addr == ADDR_WIDTH'(CLINT_MSIP_BASE + 4*h));
            cmpl_hit[h] = (addr == ADDR_WIDTH'(CLINT_MTIMECMP_BASE + 8*h));
            cmph_hit[h] = (addr == ADDR_WIDTH'(CLINT_MTIMECMP_BASE + 8*h + 4));
        end
    end

    assign mtl_hit   = (addr == ADDR_WIDTH'(CLINT_MTIMEL));
    assign mth_hit   = (addr == ADDR_WIDTH'(CLINT_MTIMEH));
    assign mapped    = (|msip_hit) | (|cmpl_hit) | (|cmph_hit) | mtl_hit | mth_hit;
    assign pslverr_o = access & ~mapped;

    always_comb begin
        rdata = '0;
        for (int h = 0; h < NUM_HART; h++) begin
            if (msip_hit[h]) rdata = {{(32-CLINT_MSIP_W){1'b0}}, msip[h]};
            if (cmpl_hit[h]) rdata = mtimecmp[h][31:0];
            if (cmph_hit[h]) rdata = mtimecmp[h][63:32];
        end
        if (mtl_hit) rdata = mtime[31:0];
        if (mth_hit) rdata = snap;
    end

    assign prdata_o = rd ? rdata : '0;

    // Per-hart state and registered interrupts. The compare uses the current
    // register values, so an irq follows its cause by exactly one cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            msip      <= '0;
            sfr_irq_o <= '0;
            tmr_irq_o <= '0;
            for (int h = 0; h < NUM_HART; h++) mtimecmp[h] <= CLINT_MTIMECMP_RST;
        end else begin
            for (int h = 0; h < NUM_HART; h++) begin
                if (wr && msip_hit[h] && pstrb_i[0]) msip[h] <= pwdata_i[0];
                if (wr && cmpl_hit[h])
                    mtimecmp[h][31:0]  <= apply_strb(mtimecmp[h][31:0], pwdata_i, pstrb_i);
                if (wr && cmph_hit[h])
                    mtimecmp[h][63:32] <= apply_strb(mtimecmp[h][63:32], pwdata_i, pstrb_i);
                sfr_irq_o[h] <= msip[h];
                tmr_irq_o[h] <= (mtime >= mtimecmp[h]);
            end
        end
    end

    // An APB write to either half wins over a coincident tick; the tick is lost
    // and the other half keeps its pre-tick value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime <= '0;
            snap  <= '0;
        end else begin
            if (wr && (mtl_hit || mth_hit)) begin
                if (mtl_hit) mtime[31:0]  <= apply_strb(mtime[31:0], pwdata_i, pstrb_i);
                if (mth_hit) mtime[63:32] <= apply_strb(mtime[63:32], pwdata_i, pstrb_i);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            // Low read freezes the high half so a low/high pair is coherent.
            if (rd && mtl_hit) snap <= mtime[63:32];
        end
    end

endmodule

// File: tb/tb_apb4_clint_mh.sv
// Directed bench for apb4_clint_mh (NUM_HART=4, PRESCALE=4).
module tb_apb4_clint_mh;

    localparam int NH = 4;

    logic          clk = 1'b0;
    logic          rst, rtc, psel, penable, pwrite;
    logic [11:0]   paddr;
    logic [31:0]   pwdata, prdata;
    logic [3:0]    pstrb;
    logic          pready, pslverr;
    logic [NH-1:0] sfr, tmr;

    int total = 0;
    int bad   = 0;

    logic [31:0] d;
    logic        e;

    always #5 clk = ~clk;

    apb4_clint_mh #(
        .NUM_HART    (NH),
        .ADDR_WIDTH  (12),
        .PRESCALE    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .rtc_clk_i (rtc),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .pstrb_i   (pstrb),
        .prdata_o  (prdata),
        .pready_o  (pready),
        .pslverr_o (pslverr),
        .sfr_irq_o (sfr),
        .tmr_irq_o (tmr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; setup phase now, access phase over the next posedge.
    task automatic apb_wr(input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] s, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = wd; pstrb = s;
        @(negedge clk);
        penable = 1'b1;
        #1 err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pstrb = 4'h0;
        @(negedge clk);
        penable = 1'b1;
        #1 begin rd = prdata; err = pslverr; end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    // One RTC rising edge, held long enough to clear the synchroniser.
    task automatic rtc_rises(input int n);
        for (int i = 0; i < n; i++) begin
            rtc = 1'b1;
            repeat (3) @(negedge clk);
            rtc = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; rtc = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_sfr", sfr, 4'b0000);
        chk("rst_tmr", tmr, 4'b0000);
        chk("pready", pready, 1'b1);
        chk("idle_prdata", prdata, 32'h0);
        apb_rd(12'h400, d, e); chk("rst_cmp0_lo", d, 32'hFFFF_FFFF); chk("rst_err", e, 1'b0);
        apb_rd(12'h404, d, e); chk("rst_cmp0_hi", d, 32'hFFFF_FFFF);
        apb_rd(12'h7F8, d, e); chk("rst_mtime_lo", d, 32'h0);
        apb_rd(12'h7FC, d, e); chk("rst_mtime_hi", d, 32'h0);

        // software interrupt on hart 2
        apb_wr(12'h008, 32'h1, 4'hF, e);
        chk("sfr_lag", sfr, 4'b0000);
        @(negedge clk);
        chk("sfr_set", sfr, 4'b0100);
        apb_rd(12'h008, d, e); chk("msip2_rd", d, 32'h1);
        apb_wr(12'h008, 32'h0, 4'hF, e);
        @(negedge clk);
        chk("sfr_clr", sfr, 4'b0000);

        // timer interrupt: 12 edges / 4 = 3 ticks
        rtc_rises(12);
        apb_rd(12'h7F8, d, e); chk("mtime3_lo", d, 32'd3);
        apb_rd(12'h7FC, d, e); chk("mtime3_hi", d, 32'd0);
        apb_wr(12'h408, 32'd3, 4'hF, e);
        @(negedge clk);
        chk("tmr_after_lo", tmr, 4'b0000);
        apb_wr(12'h40C, 32'd0, 4'hF, e);
        chk("tmr_lag", tmr, 4'b0000);
        @(negedge clk);
        chk("tmr_set", tmr, 4'b0010);
        apb_wr(12'h40C, 32'd1, 4'hF, e);
        chk("tmr_hold", tmr, 4'b0010);
        @(negedge clk);
        chk("tmr_clr", tmr, 4'b0000);

        // wrap at 2^64
        apb_wr(12'h7F8, 32'hFFFF_FFFF, 4'hF, e);
        apb_wr(12'h7FC, 32'hFFFF_FFFF, 4'hF, e);
        @(negedge clk);
        chk("tmr_all_max", tmr, 4'b1111);
        rtc_rises(4);
        apb_rd(12'h7F8, d, e); chk("wrap_lo", d, 32'h0);
        apb_rd(12'h7FC, d, e); chk("wrap_hi", d, 32'h0);
        chk("tmr_after_wrap", tmr, 4'b0000);

        // tick with carry between low and high reads
        apb_wr(12'h7F8, 32'hFFFF_FFFF, 4'hF, e);
        apb_wr(12'h7FC, 32'h5, 4'hF, e);
        rtc_rises(3);
        apb_rd(12'h7F8, d, e); chk("tear_lo", d, 32'hFFFF_FFFF);
        rtc_rises(1);
        apb_rd(12'h7FC, d, e); chk("tear_hi_snap", d, 32'h5);
        apb_rd(12'h7F8, d, e); chk("post_lo", d, 32'h0);
        apb_rd(12'h7FC, d, e); chk("post_hi", d, 32'h6);

        // write collides with tick: write wins, count still wraps
        rtc_rises(3);
        rtc = 1'b1;
        @(negedge clk);
        apb_wr(12'h7F8, 32'h10, 4'hF, e);
        rtc = 1'b0;
        repeat (3) @(negedge clk);
        apb_rd(12'h7F8, d, e); chk("coll_lo", d, 32'h10);
        apb_rd(12'h7FC, d, e); chk("coll_hi", d, 32'h6);
        rtc_rises(3);
        apb_rd(12'h7F8, d, e); chk("coll_cnt_wrapped", d, 32'h10);

        // byte strobes
        apb_wr(12'h400, 32'h1234_56AB, 4'b0001, e);
        apb_rd(12'h400, d, e); chk("strb_lo", d, 32'hFFFF_FFAB);
        apb_rd(12'h404, d, e); chk("strb_hi", d, 32'hFFFF_FFFF);

        // unmapped: hart 5 msip, gap below mtime
        apb_wr(12'h014, 32'h1, 4'hF, e); chk("unmap_wr_err", e, 1'b1);
        @(negedge clk);
        chk("unmap_sfr", sfr, 4'b0000);
        apb_rd(12'h014, d, e); chk("unmap_rd_data", d, 32'h0); chk("unmap_rd_err", e, 1'b1);
        apb_rd(12'h7F4, d, e); chk("gap_err", e, 1'b1);
        apb_rd(12'h00C, d, e); chk("msip3_err", e, 1'b0); chk("msip3_rd", d, 32'h0);

        // reset mid-prescale, with an access during reset
        rtc_rises(2);
        apb_wr(12'h000, 32'h1, 4'hF, e);
        rst = 1'b1;
        apb_wr(12'h004, 32'h1, 4'hF, e);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_sfr", sfr, 4'b0000);
        apb_rd(12'h004, d, e); chk("rst2_msip1", d, 32'h0);
        apb_rd(12'h000, d, e); chk("rst2_msip0", d, 32'h0);
        apb_rd(12'h404, d, e); chk("rst2_cmp0_hi", d, 32'hFFFF_FFFF);
        apb_rd(12'h400, d, e); chk("rst2_cmp0_lo", d, 32'hFFFF_FFFF);
        rtc_rises(3);
        apb_rd(12'h7F8, d, e); chk("rst2_no_tick", d, 32'h0);
        rtc_rises(1);
        apb_rd(12'h7F8, d, e); chk("rst2_first_tick", d, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
